// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the RV32I pipeline hazard controller:
// forwarding selects, controller states and the per-cycle pipeline control word.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned FWD_W = 2;

    typedef logic [FWD_W-1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF    = 2'b00;
    localparam fwd_sel_t FWD_EXMEM = 2'b10;
    localparam fwd_sel_t FWD_MEMWB = 2'b01;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } ctrl_state_t;

    // Enables and flush/bubble strobes applied to the pipeline registers each cycle
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } pipe_ctl_t;

    localparam pipe_ctl_t CTL_RUN = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b0
    };

    // Whole pipeline frozen; MEM/WB gets a bubble so a held WB never writes twice
    localparam pipe_ctl_t CTL_HALT = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0,
        if_id_flush: 1'b0, id_ex_flush: 1'b0, mem_wb_bubble: 1'b1
    };

    localparam pipe_ctl_t CTL_BRANCH = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        if_id_flush: 1'b1, id_ex_flush: 1'b1, mem_wb_bubble: 1'b0
    };

    localparam pipe_ctl_t CTL_LOAD_USE = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b1, ex_mem_en: 1'b1,
        if_id_flush: 1'b0, id_ex_flush: 1'b1, mem_wb_bubble: 1'b0
    };

    // A producer matches a consumer only on a real register; x0 never matches
    function automatic logic reg_hit(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle: register indices and control bits in,
// pipeline-register enables, flushes, forwarding selects and status out.
interface pipeline_hazard_ctrl_if
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) ();

    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] ex_rs1;
    logic [REG_W-1:0] ex_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             ex_MemRead;
    logic             ex_branch_taken;
    logic [REG_W-1:0] mem_rd;
    logic             mem_RegWrite;
    logic [REG_W-1:0] wb_rd;
    logic             wb_RegWrite;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_mem_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             mem_wb_bubble;
    fwd_sel_t         fwd_a;
    fwd_sel_t         fwd_b;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_MemRead, ex_branch_taken,
               mem_rd, mem_RegWrite, wb_rd, wb_RegWrite, mem_req, mem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               mem_wb_bubble, fwd_a, fwd_b, mem_fault, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, ex_MemRead, ex_branch_taken,
               mem_rd, mem_RegWrite, wb_rd, wb_RegWrite, mem_req, mem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush,
               mem_wb_bubble, fwd_a, fwd_b, mem_fault, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_unit.sv
// EX-stage operand forwarding select for one source register.
module fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] ex_rs,
    input  logic [REG_W-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             wb_reg_write,
    output fwd_sel_t         fwd_sel_c
);

    // The younger result in EX/MEM wins over the older one in MEM/WB
    always_comb begin
        fwd_sel_c = FWD_RF;
        if (mem_reg_write && reg_hit(mem_rd, ex_rs)) begin
            fwd_sel_c = FWD_EXMEM;
        end else if (wb_reg_write && reg_hit(wb_rd, ex_rs)) begin
            fwd_sel_c = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RV32I pipeline: load-use
// stalls, taken-branch flushes, data-memory wait handling with timeout fault.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_hazard_ctrl_if.slave   bus
);

    localparam int unsigned WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    ctrl_state_t       state;
    ctrl_state_t       state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic      mem_stall_c;
    logic      load_use_c;
    logic      branch_flush_c;
    pipe_ctl_t ctl_c;
    fwd_sel_t  fwd_a_c;
    fwd_sel_t  fwd_b_c;

    assign mem_stall_c = bus.mem_req & ~bus.mem_ready;
    assign load_use_c  = bus.ex_MemRead &
                         (reg_hit(bus.ex_rd, bus.id_rs1) | reg_hit(bus.ex_rd, bus.id_rs2));

    // State and wait-counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RUN;
            wait_cnt <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next state plus the pipeline control word, in hazard priority order
    always_comb begin
        state_nxt      = state;
        wait_nxt       = wait_cnt;
        ctl_c          = CTL_RUN;
        branch_flush_c = 1'b0;

        unique case (state)
            RUN: begin
                wait_nxt = '0;
                if (mem_stall_c) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                wait_nxt = wait_cnt + WAIT_W'(1);
                if (bus.mem_ready) begin
                    state_nxt = RUN;
                    wait_nxt  = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = FAULT;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = RUN;
                wait_nxt  = '0;
            end
        endcase

        // A branch seen while frozen stays in EX and is flushed once released
        if (reset) begin
            ctl_c = CTL_RUN;
        end else if (state == FAULT) begin
            ctl_c = CTL_HALT;
        end else if (mem_stall_c) begin
            ctl_c = CTL_HALT;
        end else if (bus.ex_branch_taken) begin
            ctl_c          = CTL_BRANCH;
            branch_flush_c = 1'b1;
        end else if (load_use_c) begin
            ctl_c = CTL_LOAD_USE;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctl_c.pc_en && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (branch_flush_c && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

    fwd_unit u_fwd_a (
        .ex_rs         (bus.ex_rs1),
        .mem_rd        (bus.mem_rd),
        .mem_reg_write (bus.mem_RegWrite),
        .wb_rd         (bus.wb_rd),
        .wb_reg_write  (bus.wb_RegWrite),
        .fwd_sel_c     (fwd_a_c)
    );

    fwd_unit u_fwd_b (
        .ex_rs         (bus.ex_rs2),
        .mem_rd        (bus.mem_rd),
        .mem_reg_write (bus.mem_RegWrite),
        .wb_rd         (bus.wb_rd),
        .wb_reg_write  (bus.wb_RegWrite),
        .fwd_sel_c     (fwd_b_c)
    );

    assign bus.pc_en         = ctl_c.pc_en;
    assign bus.if_id_en      = ctl_c.if_id_en;
    assign bus.id_ex_en      = ctl_c.id_ex_en;
    assign bus.ex_mem_en     = ctl_c.ex_mem_en;
    assign bus.if_id_flush   = ctl_c.if_id_flush;
    assign bus.id_ex_flush   = ctl_c.id_ex_flush;
    assign bus.mem_wb_bubble = ctl_c.mem_wb_bubble;
    assign bus.fwd_a         = reset ? FWD_RF : fwd_a_c;
    assign bus.fwd_b         = reset ? FWD_RF : fwd_b_c;
    assign bus.mem_fault     = (state == FAULT);
    assign bus.stall_cycles  = stall_cnt;
    assign bus.flush_count   = flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed vectors queue their
// expected response; a negedge monitor pops and compares each cycle.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] CMAX = '1;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
        logic       memread, br;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic       req, rdy;
    } stim_t;

    typedef struct {
        string         name;
        logic [3:0]    en;
        logic [2:0]    fl;
        logic [1:0]    fa, fb;
        logic          fault;
        logic [CW-1:0] stalls, flushes;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    logic [CW-1:0] m_stall = '0;
    logic [CW-1:0] m_flush = '0;

    pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic exp_t mk(input logic [3:0] en, input logic [2:0] fl, input logic fault);
        exp_t e;
        e.name = ""; e.en = en; e.fl = fl; e.fa = 2'b00; e.fb = 2'b00;
        e.fault = fault; e.stalls = '0; e.flushes = '0;
        return e;
    endfunction

    // en = {pc, if_id, id_ex, ex_mem}; fl = {if_id_flush, id_ex_flush, mem_wb_bubble}
    function automatic exp_t e_norm(); return mk(4'b1111, 3'b000, 1'b0); endfunction
    function automatic exp_t e_lu();   return mk(4'b0011, 3'b010, 1'b0); endfunction
    function automatic exp_t e_frz();  return mk(4'b0000, 3'b001, 1'b0); endfunction
    function automatic exp_t e_br();   return mk(4'b1111, 3'b110, 1'b0); endfunction
    function automatic exp_t e_flt();  return mk(4'b0000, 3'b001, 1'b1); endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue its expected response
    task automatic run(input string name, input stim_t s, input exp_t e);
        @(posedge clk);
        #1;
        reset               = s.rst;
        bus.id_rs1          = s.id_rs1;
        bus.id_rs2          = s.id_rs2;
        bus.ex_rs1          = s.ex_rs1;
        bus.ex_rs2          = s.ex_rs2;
        bus.ex_rd           = s.ex_rd;
        bus.ex_MemRead      = s.memread;
        bus.ex_branch_taken = s.br;
        bus.mem_rd          = s.mem_rd;
        bus.mem_RegWrite    = s.mem_rw;
        bus.wb_rd           = s.wb_rd;
        bus.wb_RegWrite     = s.wb_rw;
        bus.mem_req         = s.req;
        bus.mem_ready       = s.rdy;
        if (s.rst) begin
            m_stall = '0;
            m_flush = '0;
        end
        e.name    = name;
        e.stalls  = m_stall;
        e.flushes = m_flush;
        q.push_back(e);
        if (!e.en[3] && m_stall != CMAX) m_stall = m_stall + CW'(1);
        if (e.fl[2] && m_flush != CMAX)  m_flush = m_flush + CW'(1);
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk({e.name, ".en"},      32'({bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en}), 32'(e.en));
                chk({e.name, ".flush"},   32'({bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_bubble}), 32'(e.fl));
                chk({e.name, ".fwd"},     32'({bus.fwd_a, bus.fwd_b}), 32'({e.fa, e.fb}));
                chk({e.name, ".fault"},   32'(bus.mem_fault), 32'(e.fault));
                chk({e.name, ".stalls"},  32'(bus.stall_cycles), 32'(e.stalls));
                chk({e.name, ".flushes"}, 32'(bus.flush_count), 32'(e.flushes));
            end
        end
    end

    initial begin
        stim_t s;
        exp_t  e;
        s = idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0;
        bus.ex_MemRead = 1'b0; bus.ex_branch_taken = 1'b0; bus.mem_rd = '0;
        bus.mem_RegWrite = 1'b0; bus.wb_rd = '0; bus.wb_RegWrite = 1'b0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0;

        // Reset masks every hazard and forwarding match
        s = idle(); s.rst = 1; s.req = 1; s.br = 1; s.memread = 1; s.ex_rd = 5; s.id_rs1 = 5;
        s.mem_rw = 1; s.mem_rd = 7; s.ex_rs1 = 7;
        run("reset_busy", s, e_norm());
        run("idle", idle(), e_norm());

        // Load-use
        s = idle(); s.memread = 1; s.ex_rd = 5; s.id_rs1 = 5;
        run("lu_rs1", s, e_lu());
        run("lu_release", idle(), e_norm());
        s = idle(); s.memread = 1; s.ex_rd = 9; s.id_rs1 = 3; s.id_rs2 = 9;
        run("lu_rs2", s, e_lu());
        s = idle(); s.memread = 1; s.ex_rd = 0; s.id_rs1 = 0;
        run("lu_x0", s, e_norm());
        s = idle(); s.ex_rd = 5; s.id_rs1 = 5;
        run("lu_noload", s, e_norm());

        // Forwarding
        s = idle(); s.mem_rd = 7; s.wb_rd = 7; s.mem_rw = 1; s.wb_rw = 1; s.ex_rs1 = 7; s.ex_rs2 = 3;
        e = e_norm(); e.fa = 2'b10;
        run("fwd_exmem", s, e);
        s.mem_rw = 0;
        e = e_norm(); e.fa = 2'b01;
        run("fwd_memwb", s, e);
        s = idle(); s.mem_rw = 1; s.wb_rw = 1;
        run("fwd_x0", s, e_norm());
        s = idle(); s.mem_rd = 4; s.mem_rw = 1; s.wb_rd = 6; s.wb_rw = 1; s.ex_rs1 = 6; s.ex_rs2 = 4;
        e = e_norm(); e.fa = 2'b01; e.fb = 2'b10;
        run("fwd_both", s, e);

        // Data-memory wait of three cycles
        s = idle(); s.req = 1;
        for (int i = 0; i < 3; i++) run("mem_wait", s, e_frz());
        s.rdy = 1;
        run("mem_done", s, e_norm());
        run("idle2", idle(), e_norm());

        // Branch wins over load-use; branch during a freeze flushes on release
        s = idle(); s.br = 1; s.memread = 1; s.ex_rd = 5; s.id_rs1 = 5;
        run("br_lu", s, e_br());
        s = idle(); s.br = 1; s.req = 1;
        run("br_frz", s, e_frz());
        run("br_frz", s, e_frz());
        s.rdy = 1;
        run("br_release", s, e_br());
        run("idle3", idle(), e_norm());

        // Async reset in the middle of a wait
        s = idle(); s.req = 1;
        run("pre_rst_wait", s, e_frz());
        s.rst = 1; s.br = 1;
        run("rst_mid_wait", s, e_norm());
        run("post_rst", idle(), e_norm());

        // Timeout into a sticky fault
        s = idle(); s.req = 1;
        for (int i = 0; i < 5; i++) run("timeout_wait", s, e_frz());
        run("fault_enter", s, e_flt());
        s = idle(); s.rdy = 1; s.br = 1; s.memread = 1; s.ex_rd = 5; s.id_rs1 = 5;
        for (int i = 0; i < 14; i++) run("fault_sticky", s, e_flt());

        s = idle(); s.rst = 1;
        run("fault_rst", s, e_norm());
        run("post_fault", idle(), e_norm());
        s = idle(); s.memread = 1; s.ex_rd = 5; s.id_rs2 = 5;
        run("post_fault_lu", s, e_lu());

        for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drain", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
